// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and hazard scoreboard that sits beside the EX stage. It keeps a
// shift pipeline of the producers that are in flight in the DEPTH stages after
// EX. For every source operand in EX it picks the youngest matching producer
// to forward from. It raises a stall when that producer's result is not yet
// available, which is the case for a load that has not reached LOAD_STAGE.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   ex_valid_i     EX holds a valid instruction
//   ex_rd_addr_i   EX destination register
//   ex_regwr_i     EX instruction writes the register file
//   ex_is_load_i   EX instruction is a load
//   ex_src_addr_i  packed source addresses, operand j at [j*ADDR_W +: ADDR_W]
//   ex_src_used_i  operand j is actually read
//   flush_i        kill the EX instruction this cycle
//   cnt_clr_i      clear the stall counter
//   fw_sel_o       per-operand select: 0 = register file, k = tracked stage k
//   stall_o        hold the front end and EX, and insert a bubble
//   stall_cnt_o    saturating count of stalled cycles
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ex_valid_i,
    input  logic [ADDR_W-1:0]        ex_rd_addr_i,
    input  logic                     ex_regwr_i,
    input  logic                     ex_is_load_i,
    input  logic [NSRC*ADDR_W-1:0]   ex_src_addr_i,
    input  logic [NSRC-1:0]          ex_src_used_i,
    input  logic                     flush_i,
    input  logic                     cnt_clr_i,
    output logic [NSRC*SEL_W-1:0]    fw_sel_o,
    output logic                     stall_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    // Record k is the instruction currently in tracked stage k (1 = MEM).
    logic [DEPTH:1]    rec_valid;
    logic [DEPTH:1]    rec_regwr;
    logic [DEPTH:1]    rec_load;
    logic [ADDR_W-1:0] rec_rd [1:DEPTH];

    logic [NSRC*SEL_W-1:0] sel;
    logic [NSRC-1:0]       op_blocked;
    logic                  stall;
    logic                  push;
    logic [CNT_W-1:0]      stall_cnt;

    // Stages are scanned from oldest to youngest, so a younger match simply
    // overwrites an older one. That makes the youngest producer win. The
    // readiness flag follows the chosen record only, so an older ready copy
    // of the same register cannot hide a pending load.
    always_comb begin
        sel        = '0;
        op_blocked = '0;
        for (int j = 0; j < NSRC; j++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (rec_valid[k] && rec_regwr[k] && (rec_rd[k] != '0) &&
                    (rec_rd[k] == ex_src_addr_i[j*ADDR_W +: ADDR_W]) &&
                    ex_src_used_i[j]) begin
                    sel[j*SEL_W +: SEL_W] = SEL_W'(k);
                    op_blocked[j]         = rec_load[k] && (k < LOAD_STAGE);
                end
            end
        end
    end

    assign stall       = ex_valid_i & ~flush_i & ~rst_i & (|op_blocked);
    assign push        = ex_valid_i & ~stall & ~flush_i;
    assign fw_sel_o    = rst_i ? '0 : sel;
    assign stall_o     = stall;
    assign stall_cnt_o = stall_cnt;

    // The pipeline advances on every edge, even while stalling. The stalled
    // EX instruction is replaced by a bubble, so older producers keep moving
    // toward their forwardable stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rec_valid <= '0;
            rec_regwr <= '0;
            rec_load  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rec_rd[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                rec_valid[k] <= rec_valid[k-1];
                rec_regwr[k] <= rec_regwr[k-1];
                rec_load[k]  <= rec_load[k-1];
                rec_rd[k]    <= rec_rd[k-1];
            end
            rec_valid[1] <= push;
            rec_regwr[1] <= ex_regwr_i;
            rec_load[1]  <= ex_is_load_i;
            rec_rd[1]    <= ex_rd_addr_i;

            if (cnt_clr_i) begin
                stall_cnt <= '0;
            end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_scoreboard
//
// Self-checking bench for fwd_scoreboard. It runs directed scenarios for
// ALU forwarding, youngest-wins, load-use, r0/unused operands, flush,
// counter saturation and mid-stall reset. These are followed by randomized
// traffic. A queue-based model of in-flight producers supplies the expected
// outputs every cycle.
// ---------------------------------------------------------------------------
module tb_fwd_scoreboard;

    localparam int ADDR_W     = 5;
    localparam int NSRC       = 2;
    localparam int DEPTH      = 2;
    localparam int LOAD_STAGE = 2;
    localparam int SEL_W      = 3;
    localparam int CNT_W      = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst;
    logic                   ex_valid;
    logic [ADDR_W-1:0]      ex_rd;
    logic                   ex_regwr;
    logic                   ex_load;
    logic [NSRC*ADDR_W-1:0] ex_src;
    logic [NSRC-1:0]        ex_used;
    logic                   flush;
    logic                   cnt_clr;
    logic [NSRC*SEL_W-1:0]  fw_sel;
    logic                   stall;
    logic [CNT_W-1:0]       stall_cnt;

    fwd_scoreboard #(
        .ADDR_W(ADDR_W), .NSRC(NSRC), .DEPTH(DEPTH),
        .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd),
        .ex_regwr_i(ex_regwr), .ex_is_load_i(ex_load), .ex_src_addr_i(ex_src),
        .ex_src_used_i(ex_used), .flush_i(flush), .cnt_clr_i(cnt_clr),
        .fw_sel_o(fw_sel), .stall_o(stall), .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } prod_t;

    // hist[0] is the youngest producer (tracked stage 1).
    prod_t hist[$];
    int    cnt_model;
    int    exp_sel [NSRC];
    bit    exp_stall;
    int    checks = 0;
    int    errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        prod_t b;
        b.valid = 0; b.rd = 0; b.wr = 0; b.ld = 0;
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(b);
        cnt_model = 0;
    endtask

    // Expected outputs follow from the current producer list and EX inputs.
    task automatic modelCheck();
        bit pending;
        pending = 0;
        for (int j = 0; j < NSRC; j++) begin
            bit [4:0] s;
            s = ex_src[j*ADDR_W +: ADDR_W];
            exp_sel[j] = 0;
            if (ex_used[j] && s != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (exp_sel[j] == 0 && hist[i].valid && hist[i].wr && hist[i].rd == s) begin
                        exp_sel[j] = i + 1;
                        if (hist[i].ld && (i + 1) < LOAD_STAGE) pending = 1;
                    end
                end
            end
            if (rst) exp_sel[j] = 0;
        end
        exp_stall = ex_valid && !flush && !rst && pending;
        checkOutput("sel0", 32'(fw_sel[0 +: SEL_W]), 32'(exp_sel[0]));
        checkOutput("sel1", 32'(fw_sel[SEL_W +: SEL_W]), 32'(exp_sel[1]));
        checkOutput("stall", 32'(stall), 32'(exp_stall));
        checkOutput("cnt", 32'(stall_cnt), 32'(cnt_model));
    endtask

    task automatic applyStimulus(input bit v, input bit [4:0] rd, input bit wr, input bit ld,
                                 input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] used,
                                 input bit fl, input bit clr, input bit rs);
        ex_valid = v; ex_rd = rd; ex_regwr = wr; ex_load = ld;
        ex_src = {s1, s0}; ex_used = used; flush = fl; cnt_clr = clr; rst = rs;
        #4;
        modelCheck();
    endtask

    // Clock edge: the model advances with the stall value it predicted.
    task automatic advance();
        prod_t n;
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            n.valid = ex_valid && !exp_stall && !flush;
            n.rd = ex_rd; n.wr = ex_regwr; n.ld = ex_load;
            hist.push_front(n);
            void'(hist.pop_back());
            if (cnt_clr) cnt_model = 0;
            else if (exp_stall && cnt_model < CNT_MAX) cnt_model++;
        end
        #1;
    endtask

    initial begin
        ex_valid = 0; ex_rd = 0; ex_regwr = 0; ex_load = 0; ex_src = 0;
        ex_used = 0; flush = 0; cnt_clr = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        modelReset();

        // Outputs held at zero while reset is asserted.
        applyStimulus(1, 5'd3, 1, 1, 5'd3, 5'd3, 2'b11, 0, 0, 1);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        advance();

        // Back-to-back ALU dependency.
        applyStimulus(1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd6, 1, 0, 5'd5, 5'd0, 2'b01, 0, 0, 0);
        checkOutput("alu_sel0_k1", 32'(fw_sel[0 +: SEL_W]), 32'd1);
        checkOutput("alu_nostall", 32'(stall), 32'd0);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd5, 5'd0, 2'b01, 0, 0, 0);
        checkOutput("alu_sel0_k2", 32'(fw_sel[0 +: SEL_W]), 32'd2);
        advance();

        // Youngest wins on both operands, then with the younger regwr off.
        applyStimulus(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd7, 5'd7, 2'b11, 0, 0, 0);
        checkOutput("young_sel0", 32'(fw_sel[0 +: SEL_W]), 32'd1);
        checkOutput("young_sel1", 32'(fw_sel[SEL_W +: SEL_W]), 32'd1);
        advance();
        applyStimulus(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd7, 0, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd7, 5'd7, 2'b11, 0, 0, 0);
        checkOutput("nowr_sel0", 32'(fw_sel[0 +: SEL_W]), 32'd2);
        checkOutput("nowr_sel1", 32'(fw_sel[SEL_W +: SEL_W]), 32'd2);
        advance();

        // Load-use: one stall cycle, then forward from stage 2.
        applyStimulus(1, 5'd9, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd10, 1, 0, 5'd0, 5'd9, 2'b10, 0, 0, 0);
        checkOutput("lu_stall", 32'(stall), 32'd1);
        advance();
        applyStimulus(1, 5'd10, 1, 0, 5'd0, 5'd9, 2'b10, 0, 0, 0);
        checkOutput("lu_sel1_k2", 32'(fw_sel[SEL_W +: SEL_W]), 32'd2);
        checkOutput("lu_released", 32'(stall), 32'd0);
        checkOutput("lu_cnt", 32'(stall_cnt), 32'd1);
        advance();

        // r0 is never forwarded; an unused operand never matches.
        applyStimulus(1, 5'd12, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd0, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd0, 5'd12, 2'b01, 0, 0, 0);
        checkOutput("r0_sel", 32'(fw_sel), 32'd0);
        checkOutput("r0_stall", 32'(stall), 32'd0);
        advance();

        // Flush beats stall and pushes nothing.
        applyStimulus(1, 5'd14, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd15, 1, 0, 5'd14, 5'd0, 2'b01, 1, 0, 0);
        checkOutput("flush_nostall", 32'(stall), 32'd0);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd15, 5'd14, 2'b11, 0, 0, 0);
        checkOutput("flush_nopush", 32'(fw_sel[0 +: SEL_W]), 32'd0);
        checkOutput("flush_old_k2", 32'(fw_sel[SEL_W +: SEL_W]), 32'd2);
        advance();

        // Counter clear, five stalls, saturation, clear again.
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 0, 1, 0);
        advance();
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1, 5'd20, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0);
            advance();
            applyStimulus(1, 5'd0, 0, 0, 5'd20, 5'd0, 2'b01, 0, 0, 0);
            checkOutput("sat_stall", 32'(stall), 32'd1);
            advance();
            applyStimulus(1, 5'd0, 0, 0, 5'd20, 5'd0, 2'b01, 0, 0, 0);
            advance();
        end
        checkOutput("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 0, 1, 0);
        advance();
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        checkOutput("clr_cnt", 32'(stall_cnt), 32'd0);
        advance();

        // Reset mid-stall invalidates every record.
        applyStimulus(1, 5'd22, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd22, 5'd0, 2'b01, 0, 0, 0);
        checkOutput("mid_stall", 32'(stall), 32'd1);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd22, 5'd0, 2'b01, 0, 0, 1);
        advance();
        applyStimulus(1, 5'd0, 0, 0, 5'd22, 5'd0, 2'b01, 0, 0, 0);
        checkOutput("post_rst_stall", 32'(stall), 32'd0);
        checkOutput("post_rst_sel", 32'(fw_sel), 32'd0);
        advance();

        // Randomized traffic over a small register range to force overlaps.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 8,
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 2) == 0,
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 49) == 0);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-operand EX-stage forwarding unit.
- Keeps an internal shift pipeline of in-flight producer records (destination address, regwrite, load flag) for DEPTH stages downstream of EX.
- For each of NSRC source operands in EX, selects the youngest matching producer to forward from. Raises a stall when that producer's data is not yet available, for example a load before LOAD_STAGE.
- Sits beside the EX stage. Drives the operand-mux selects and the pipeline stall, and provides a stall performance counter.

Parameters:
- ADDR_W, 5: register address width.
- NSRC, 2: number of source operands checked per cycle.
- DEPTH, 2: tracked stages after EX (1 = MEM, 2 = WB, ...). Legal range 1..7.
- LOAD_STAGE, 2: first tracked stage at which a load's result is forwardable. Legal range 1..DEPTH.
- SEL_W, 3: width of each select field. Must hold the value DEPTH.
- CNT_W, 16: stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ex_valid_i  in  1  EX holds a valid instruction.
- ex_rd_addr_i  in  ADDR_W  EX destination register.
- ex_regwr_i  in  1  EX instruction writes the register file.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_src_addr_i  in  NSRC*ADDR_W  source addresses; operand j occupies bits [j*ADDR_W +: ADDR_W].
- ex_src_used_i  in  NSRC  operand j is actually read.
- flush_i  in  1  kill the EX instruction this cycle.
- cnt_clr_i  in  1  clear the stall counter.
- fw_sel_o  out  NSRC*SEL_W  per-operand select: 0 = register file, k = tracked stage k.
- stall_o  out  1  hold the front end and EX; insert a bubble.
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State: DEPTH records, each {valid, rd, regwr, is_load}. Record k is the instruction in tracked stage k.
- Reset (rst_i high at the clock edge): all records valid=0, stall_cnt_o=0.
- Outputs while rst_i is high: fw_sel_o=0 and stall_o=0, regardless of inputs.
- Match: operand j matches record k when all of the following hold:
  - valid(k)=1 and regwr(k)=1;
  - rd(k) != 0;
  - rd(k) == src_j;
  - ex_src_used_i[j]=1.
- Selection: fw_sel_o[j] = the lowest k that matches (youngest producer wins), else 0. This priority is identical for every operand.
- Ready: the selected record k is ready unless is_load(k)=1 and k < LOAD_STAGE.
- stall_o = ex_valid_i & ~flush_i & (some operand's selected record is not ready).
  - Only the youngest match is considered. An older, ready match never cancels the stall.
- fw_sel_o and stall_o are combinational from the current records and EX inputs. No added latency.
- Shift at every clock edge when not in reset: record k+1 <= record k, for k = 1..DEPTH-1. Record DEPTH is discarded.
- New record 1:
  - If ex_valid_i=1 and stall_o=0 and flush_i=0: {1, ex_rd_addr_i, ex_regwr_i, ex_is_load_i}.
  - Otherwise a bubble (valid=0).
- A stall therefore lets older producers advance. A load dependency resolves after (LOAD_STAGE-1) stall cycles.
- flush_i has priority over stall: no stall is raised and no record is pushed. Records already in tracked stages are unaffected.
- Stall counter:
  - Increments by 1 on each edge where stall_o=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr_i=1 sets it to 0 and has priority over increment.
  - rst_i has priority over everything.
- Register 0 is never forwarded and never causes a stall.
- A record with regwr=0 never matches, even when rd equals a source address.
- Reset mid-stall: all records are invalidated at that edge. stall_o is 0 on the next cycle unless a new dependency forms.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: EX = add rd=5, then EX = sub with src0=5.
  - Required: fw_sel_o[0]=1, stall_o=0.
  - One cycle later with src0=5 still present: fw_sel_o[0]=2.
- Youngest wins, both operands:
  - Stimulus: consecutive writers to r7 (older) then r7 (younger); next EX uses src0=src1=7.
  - Required: both select fields = 1.
  - Disable the younger writer's regwr: both select fields = 2.
- Load-use, LOAD_STAGE=2:
  - Stimulus: lw rd=9 then EX with src1=9.
  - Required: stall_o=1 for exactly one cycle; record 1 becomes a bubble; next cycle fw_sel_o[1]=2, stall_o=0; stall_cnt_o=1.
- r0 and unused operands:
  - Stimulus: producer rd=0 with regwr=1, then EX src0=0; also a matching rd with ex_src_used_i[1]=0.
  - Required: fw_sel_o=0, stall_o=0.
- Flush versus stall:
  - Stimulus: load-use condition with flush_i=1.
  - Required: stall_o=0, nothing pushed; next cycle record 1 is invalid.
- Counter and reset:
  - Stimulus: with CNT_W=2, force 5 stall cycles.
  - Required: stall_cnt_o saturates at 3; cnt_clr_i resets it to 0.
  - Assert rst_i mid-stall: next cycle all fw_sel_o=0, stall_o=0.
